lif_post_neuron: RTL and testbench



---
 rtl/lif_post_neuron.sv | 124 ++++++++++++
 tb/tb_lif_post_neuron.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lif_post_neuron.sv
// Leaky integrate-and-fire postsynaptic neuron with a refractory period.
// Optional adaptive threshold is enabled by defining LIF_ADAPT_THRESH_EN.
module lif_post_neuron #(
  parameter int NUM_PRE    = 4,
  parameter int W_WIDTH    = 4,
  parameter int V_WIDTH    = 8,
  parameter int THRESHOLD  = 48,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRACT    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NUM_PRE-1:0]         pre_spike,
  input  logic [NUM_PRE*W_WIDTH-1:0] weight,
  output logic                       post_spike,
  output logic [V_WIDTH-1:0]         membrane,
  output logic                       refractory,
  output logic [7:0]                 spike_count
);

  localparam int SW   = W_WIDTH + $clog2(NUM_PRE);
  localparam int NW   = V_WIDTH + 1;
  localparam int CW   = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam int VMAX = (2 ** V_WIDTH) - 1;

  typedef enum logic {INTEG, REFR} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sum;
  logic [NW-1:0] v_next;
  logic [NW-1:0] thr_eff;
  logic          fire;

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < NUM_PRE; i++) begin
      if (pre_spike[i])
        sum = sum + SW'(weight[(NUM_PRE-1-i)*W_WIDTH +: W_WIDTH]);
    end
  end

  always_comb begin
    v_next = {1'b0, membrane} - NW'(membrane >> LEAK_SHIFT) + NW'(sum);
  end

`ifdef LIF_ADAPT_THRESH_EN
  logic [5:0]  offset;
  logic [NW:0] thr_raw;

  always_comb begin
    thr_raw = (NW+1)'(THRESHOLD) + (NW+1)'(offset);
    thr_eff = (thr_raw > (NW+1)'(VMAX)) ? NW'(VMAX) : thr_raw[NW-1:0];
  end

  // Offset jumps by 8 per fire and decays by 1 per active non-firing edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      offset <= '0;
    end else if (state == INTEG && en) begin
      if (fire)
        offset <= (offset > 6'd55) ? 6'd63 : offset + 6'd8;
      else if (offset != '0)
        offset <= offset - 6'd1;
    end
  end
`else
  always_comb begin
    thr_eff = NW'(THRESHOLD);
  end
`endif

  always_comb begin
    fire = (state == INTEG) && en && (v_next >= thr_eff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INTEG;
      cnt         <= '0;
      membrane    <= '0;
      post_spike  <= 1'b0;
      refractory  <= 1'b0;
      spike_count <= '0;
    end else begin
      case (state)
        INTEG: begin
          post_spike <= 1'b0;
          if (en) begin
            if (fire) begin
              post_spike <= 1'b1;
              membrane   <= '0;
              if (spike_count != 8'hFF)
                spike_count <= spike_count + 8'd1;
              if (REFRACT > 0) begin
                state      <= REFR;
                refractory <= 1'b1;
                cnt        <= CW'(REFRACT);
              end
            end else begin
              // Top bit of the widened result flags overflow past VMAX.
              membrane <= v_next[NW-1] ? '1 : v_next[V_WIDTH-1:0];
            end
          end
        end
        REFR: begin
          post_spike <= 1'b0;
          membrane   <= '0;
          cnt        <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state      <= INTEG;
            refractory <= 1'b0;
          end
        end
        default: begin
          state      <= INTEG;
          refractory <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lif_post_neuron.sv
// Directed self-checking bench for lif_post_neuron at default parameters.
module tb_lif_post_neuron;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  pre_spike;
  logic [15:0] weight;
  logic        post_spike;
  logic [7:0]  membrane;
  logic        refractory;
  logic [7:0]  spike_count;

  int checks = 0;
  int errors = 0;

  lif_post_neuron #(
    .NUM_PRE(4), .W_WIDTH(4), .V_WIDTH(8),
    .THRESHOLD(48), .LEAK_SHIFT(3), .REFRACT(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pre_spike(pre_spike), .weight(weight),
    .post_spike(post_spike), .membrane(membrane), .refractory(refractory),
    .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'($urandom);
    pre_spike = 4'($urandom);
    weight = 16'($urandom);
    step();
    pre_spike = 4'($urandom);
    step();
    checks++;
    if (post_spike !== 1'b0) begin errors++; $display("FAIL reset_post got %0b exp 0", post_spike); end
    checks++;
    if (membrane !== 8'd0) begin errors++; $display("FAIL reset_membrane got %0d exp 0", membrane); end
    checks++;
    if (refractory !== 1'b0) begin errors++; $display("FAIL reset_refr got %0b exp 0", refractory); end
    checks++;
    if (spike_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", spike_count); end
    rst = 1'b0;
  endtask

  task automatic test_integration();
    int exp_v[3] = '{15, 29, 41};
    int edges;
    int exp_edges;
    en = 1'b1; pre_spike = 4'b0001; weight = 16'hF000;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (membrane !== 8'(exp_v[k]) || post_spike !== 1'b0) begin
        errors++; $display("FAIL integ_v%0d got v=%0d p=%0b exp v=%0d p=0", k, membrane, post_spike, exp_v[k]);
      end
    end
    step();
    checks++;
    if (post_spike !== 1'b1 || membrane !== 8'd0 || spike_count !== 8'd1 || refractory !== 1'b1) begin
      errors++; $display("FAIL integ_fire got p=%0b v=%0d c=%0d r=%0b exp p=1 v=0 c=1 r=1", post_spike, membrane, spike_count, refractory);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (refractory !== 1'b1 || post_spike !== 1'b0 || membrane !== 8'd0) begin
        errors++; $display("FAIL integ_refr%0d got r=%0b p=%0b v=%0d exp r=1 p=0 v=0", k, refractory, post_spike, membrane);
      end
    end
    step();
    checks++;
    if (refractory !== 1'b0 || membrane !== 8'd0) begin
      errors++; $display("FAIL integ_refr_end got r=%0b v=%0d exp r=0 v=0", refractory, membrane);
    end
    step();
    checks++;
    if (membrane !== 8'd15) begin errors++; $display("FAIL integ_resume got %0d exp 15", membrane); end
`ifdef LIF_ADAPT_THRESH_EN
    exp_edges = 4;
`else
    exp_edges = 3;
`endif
    edges = 0;
    while (post_spike !== 1'b1 && edges < 20) begin
      step();
      edges++;
    end
    checks++;
    if (edges !== exp_edges) begin
      errors++; $display("FAIL integ_second_fire got %0d edges exp %0d", edges, exp_edges);
    end
  endtask

  task automatic test_leak();
    int exp_v[5] = '{36, 32, 28, 25, 22};
    en = 1'b1; pre_spike = 4'b0001; weight = 16'hF000;
    do_reset();
    repeat (3) step();
    checks++;
    if (membrane !== 8'd41) begin errors++; $display("FAIL leak_start got %0d exp 41", membrane); end
    pre_spike = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (membrane !== 8'(exp_v[k])) begin
        errors++; $display("FAIL leak_v%0d got %0d exp %0d", k, membrane, exp_v[k]);
      end
    end
    pre_spike = 4'b0001;
    do_reset();
    repeat (3) step();
    en = 1'b0;
    repeat (3) step();
    checks++;
    if (membrane !== 8'd41) begin errors++; $display("FAIL leak_en0_hold got %0d exp 41", membrane); end
    en = 1'b1; weight = 16'h7000;
    do_reset();
    step();
    pre_spike = 4'b0000;
    repeat (3) step();
    checks++;
    if (membrane !== 8'd7) begin errors++; $display("FAIL leak_floor got %0d exp 7", membrane); end
  endtask

  task automatic test_refractory_period();
    logic exp_p;
    logic exp_r;
    en = 1'b1; pre_spike = 4'hF; weight = 16'hFFFF;
    do_reset();
    for (int k = 1; k <= 11; k++) begin
      if (k == 3) weight = 16'h0000;
      if (k == 5) weight = 16'hFFFF;
      step();
      exp_p = (k == 1 || k == 6 || k == 11);
      exp_r = ((k - 1) % 5) < 4;
      checks++;
      if (post_spike !== exp_p || refractory !== exp_r) begin
        errors++; $display("FAIL period_c%0d got p=%0b r=%0b exp p=%0b r=%0b", k, post_spike, refractory, exp_p, exp_r);
      end
    end
    checks++;
    if (spike_count !== 8'd3) begin errors++; $display("FAIL period_count got %0d exp 3", spike_count); end
  endtask

  task automatic test_reset_mid();
    en = 1'b1; pre_spike = 4'hF; weight = 16'hFFFF;
    do_reset();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (refractory !== 1'b0 || spike_count !== 8'd0 || membrane !== 8'd0 || post_spike !== 1'b0) begin
      errors++; $display("FAIL midrst got r=%0b c=%0d v=%0d p=%0b exp 0 0 0 0", refractory, spike_count, membrane, post_spike);
    end
    step();
    checks++;
    if (post_spike !== 1'b1 || spike_count !== 8'd1) begin
      errors++; $display("FAIL midrst_resume got p=%0b c=%0d exp p=1 c=1", post_spike, spike_count);
    end
  endtask

  task automatic test_saturation();
    en = 1'b1; pre_spike = 4'hF; weight = 16'hFFFF;
    do_reset();
    repeat (1271) step();
    checks++;
    if (spike_count !== 8'd255) begin errors++; $display("FAIL sat_reach got %0d exp 255", spike_count); end
    repeat (229) step();
    checks++;
    if (spike_count !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d exp 255", spike_count); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pre_spike = '0; weight = '0;
    test_reset();
    test_integration();
    test_leak();
    test_refractory_period();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
